// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and constants for the ADC capture controller.
// Provides capture mode / FSM state enums, overflow counter width, channel-index width helper.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        CONT  = 2'd0,
        BURST = 2'd1,
        TRIG  = 2'd2,
        RSVD  = 2'd3
    } capture_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } capture_state_t;

    localparam int OVF_W = 16;

    // Width of a channel index; a single-channel build still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_capture_if.sv
// adc_capture_if: sample, control, status and readout signals of adc_capture_ctrl.
// master = driver side (deserialisers + register/readout logic), slave = the controller.
interface adc_capture_if
    import adc_capture_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_WIDTH   = 12,
    parameter int LEN_W        = 16,
    parameter int FRAME_W      = 96,
    parameter int CH_W         = 3
);
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] sample_in;
    logic                               sample_valid;
    logic [1:0]                         mode;
    logic                               start;
    logic                               abort;
    logic [LEN_W-1:0]                   burst_len;
    logic [CH_W-1:0]                    trig_ch;
    logic [DATA_WIDTH-1:0]              trig_level;
    logic                               trig_rising;
    logic [NUM_CHANNELS-1:0]            chan_mask;
    logic                               sample_en;
    logic                               busy;
    logic                               done;
    logic                               rd_en;
    logic [FRAME_W-1:0]                 dout;
    logic                               not_empty;
    logic                               full;
    logic [OVF_W-1:0]                   overflow_cnt;

    modport master (
        output sample_in, sample_valid, mode, start, abort, burst_len,
        output trig_ch, trig_level, trig_rising, chan_mask, rd_en,
        input  sample_en, busy, done, dout, not_empty, full, overflow_cnt
    );

    modport slave (
        input  sample_in, sample_valid, mode, start, abort, burst_len,
        input  trig_ch, trig_level, trig_rising, chan_mask, rd_en,
        output sample_en, busy, done, dout, not_empty, full, overflow_cnt
    );

endinterface

// File: rtl/adc_capture_ctrl_fifo.sv
// sync_frame_fifo: single-clock first-word-fall-through frame FIFO.
// Ports: clk, rstn, wr_en_i/wr_data_i, rd_en_i, rd_data_o (0 while empty), full_o, not_empty_o.
module sync_frame_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             not_empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             push;
    logic             pop;

    assign not_empty_o = (wptr_q != rptr_q);
    // Extra pointer MSB tells full from empty when the indices match.
    assign full_o = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign pop  = rd_en_i && not_empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = wr_en_i && (!full_o || rd_en_i);

    assign rd_data_o = not_empty_o ? mem[rptr_q[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: captures masked multi-channel ADC frames into a FWFT frame FIFO
// in continuous, burst or threshold-triggered mode. Ports: clk, rstn, bus (adc_capture_if.slave).
// Optional ADC_CAPTURE_TIMESTAMP_EN appends a free-running TS_WIDTH timestamp as frame MSBs.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_WIDTH   = 12,
    parameter int FIFO_DEPTH   = 512,
    parameter int LEN_W        = 16,
    parameter int TS_WIDTH     = 32
) (
    input logic         clk,
    input logic         rstn,
    adc_capture_if.slave bus
);
    localparam int CH_W  = ch_w(NUM_CHANNELS);
    localparam int SMP_W = NUM_CHANNELS * DATA_WIDTH;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    localparam int FRAME_W = SMP_W + TS_WIDTH;
`else
    localparam int FRAME_W = SMP_W;
`endif

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 || TS_WIDTH < 1 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_err
        $error("adc_capture_ctrl: unsupported parameter set");
    end

    capture_state_t          state_q, state_d;
    capture_mode_t           mode_q;
    capture_mode_t           start_mode;
    logic [LEN_W-1:0]        len_q;
    logic [CH_W-1:0]         trig_ch_q;
    logic [DATA_WIDTH-1:0]   level_q;
    logic                    rising_q;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [DATA_WIDTH-1:0]   prev_q;
    logic                    prev_vld_q;
    logic [LEN_W-1:0]        cnt_q;
    logic [FRAME_W-1:0]      frm_q, frm_d;
    logic                    frm_vld_q;
    logic [OVF_W-1:0]        ovf_q;
    logic                    busy_q;
    logic                    sen_q;
    logic                    done_q, done_d;
    logic [SMP_W-1:0]        masked;
    logic [DATA_WIDTH-1:0]   cur;
    logic                    fire;
    logic                    start_ok;
    logic                    last;
    logic                    take;
    logic                    fifo_full;

    assign start_mode = capture_mode_t'(bus.mode);
    assign start_ok   = bus.start && !bus.abort &&
                        (state_q == IDLE) && (start_mode != RSVD);

    assign cur  = bus.sample_in[trig_ch_q*DATA_WIDTH +: DATA_WIDTH];
    assign fire = prev_vld_q &&
                  (rising_q ? (prev_q <  level_q && cur >= level_q)
                            : (prev_q >= level_q && cur <  level_q));

    // Final counted frame sits in the register stage; its write edge ends the burst.
    assign last = frm_vld_q && (mode_q != CONT) && (cnt_q == len_q);

    // Frames are counted when registered, so no extra frame slips in behind the last one.
    assign take = !bus.abort && bus.sample_valid &&
                  (((state_q == CAPTURE) && ((mode_q == CONT) || (cnt_q < len_q))) ||
                   ((state_q == ARMED) && fire && (len_q != '0)));

    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (mask_q[i]) begin
                masked[i*DATA_WIDTH +: DATA_WIDTH] = bus.sample_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign frm_d = {ts_q, masked};
`else
    assign frm_d = masked;
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (start_mode == TRIG) begin
                            state_d = ARMED;
                        end else if (start_mode == BURST && bus.burst_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = CAPTURE;
                        end
                    end
                end
                ARMED: begin
                    if (bus.sample_valid && fire) begin
                        if (len_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mode_q     <= CONT;
            len_q      <= '0;
            trig_ch_q  <= '0;
            level_q    <= '0;
            rising_q   <= 1'b0;
            mask_q     <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            cnt_q      <= '0;
            frm_q      <= '0;
            frm_vld_q  <= 1'b0;
            ovf_q      <= '0;
            busy_q     <= 1'b0;
            sen_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != IDLE);
            sen_q     <= (state_d != IDLE);
            done_q    <= done_d;
            frm_vld_q <= take;
            if (take) begin
                frm_q <= frm_d;
            end
            if (start_ok) begin
                mode_q     <= start_mode;
                len_q      <= bus.burst_len;
                trig_ch_q  <= bus.trig_ch;
                level_q    <= bus.trig_level;
                rising_q   <= bus.trig_rising;
                mask_q     <= bus.chan_mask;
                cnt_q      <= '0;
                prev_vld_q <= 1'b0;
                ovf_q      <= '0;
            end else begin
                if (take) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (frm_vld_q && fifo_full && !bus.rd_en && ovf_q != '1) begin
                    ovf_q <= ovf_q + 1'b1;
                end
                if (state_q == ARMED && bus.sample_valid) begin
                    prev_q     <= cur;
                    prev_vld_q <= 1'b1;
                end
            end
        end
    end

    sync_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .wr_en_i     (frm_vld_q),
        .wr_data_i   (frm_q),
        .rd_en_i     (bus.rd_en),
        .rd_data_o   (bus.dout),
        .full_o      (fifo_full),
        .not_empty_o (bus.not_empty)
    );

    assign bus.full         = fifo_full;
    assign bus.busy         = busy_q;
    assign bus.sample_en    = sen_q;
    assign bus.done         = done_q;
    assign bus.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: scoreboard bench for adc_capture_ctrl.
// Expected frames are queued as stimulus is driven and popped as the FIFO is read.
module tb_adc_capture_ctrl;
    import adc_capture_pkg::*;

    localparam int NC    = 8;
    localparam int DW    = 12;
    localparam int LW    = 16;
    localparam int DEPTH = 16;
    localparam int TSW   = 32;
    localparam int CW    = 3;
    localparam int SMP_W = NC * DW;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    localparam int FW = SMP_W + TSW;
`else
    localparam int FW = SMP_W;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    adc_capture_if #(
        .NUM_CHANNELS (NC),
        .DATA_WIDTH   (DW),
        .LEN_W        (LW),
        .FRAME_W      (FW),
        .CH_W         (CW)
    ) bus ();

    adc_capture_ctrl #(
        .NUM_CHANNELS (NC),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .LEN_W        (LW),
        .TS_WIDTH     (TSW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic done_busy = 1'b0;
    logic [SMP_W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.done) begin
            done_seen++;
            done_busy = bus.busy;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SMP_W-1:0] mkf(input int k);
        logic [SMP_W-1:0] f;
        for (int i = 0; i < NC; i++) begin
            f[i*DW +: DW] = DW'(k + 16 * i);
        end
        return f;
    endfunction

    function automatic logic [SMP_W-1:0] mkc2(input int k, input logic [DW-1:0] v);
        logic [SMP_W-1:0] f;
        f = mkf(k);
        f[2*DW +: DW] = v;
        return f;
    endfunction

    function automatic logic [SMP_W-1:0] msk(input logic [SMP_W-1:0] f, input logic [NC-1:0] m);
        logic [SMP_W-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++) begin
            if (m[i]) r[i*DW +: DW] = f[i*DW +: DW];
        end
        return r;
    endfunction

    task automatic send(input logic [SMP_W-1:0] f);
        bus.sample_in    = f;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic start_acq(input logic [1:0] m, input int len, input int ch,
                             input logic [DW-1:0] lvl, input logic rising,
                             input logic [NC-1:0] cm);
        bus.mode        = m;
        bus.burst_len   = LW'(len);
        bus.trig_ch     = CW'(ch);
        bus.trig_level  = lvl;
        bus.trig_rising = rising;
        bus.chan_mask   = cm;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        int w;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!bus.not_empty && w < 16) begin
                tick();
                w++;
            end
            if (!bus.not_empty) begin
                check({tag, "_timeout"}, 0, 1);
                exp_q.delete();
                break;
            end
            check(tag, bus.dout[SMP_W-1:0], exp_q.pop_front());
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
        end
        check({tag, "_empty"}, bus.not_empty, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [SMP_W-1:0] f;

        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.mode         = 2'd0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.burst_len    = '0;
        bus.trig_ch      = '0;
        bus.trig_level   = '0;
        bus.trig_rising  = 1'b0;
        bus.chan_mask    = '0;
        bus.rd_en        = 1'b0;

        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_sample_en", bus.sample_en, 0);
        check("rst_not_empty", bus.not_empty, 0);
        check("rst_full", bus.full, 0);
        check("rst_ovf", bus.overflow_cnt, 0);
        check("rst_dout", bus.dout, 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Reserved mode is ignored.
        start_acq(2'd3, 4, 0, '0, 1'b1, '1);
        check("rsvd_busy", bus.busy, 0);

`ifdef ADC_CAPTURE_TIMESTAMP_EN
        begin
            logic [TSW-1:0] ts1;
            logic [TSW-1:0] ts2;
            start_acq(2'd0, 0, 0, '0, 1'b1, '1);
            send(mkf(1));
            tick();
            tick();
            send(mkf(2));
            tick();
            tick();
            ts1 = bus.dout[FW-1:SMP_W];
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
            ts2 = bus.dout[FW-1:SMP_W];
            check("ts_delta", ts2 - ts1, 3);
            bus.rd_en = 1'b1;
            tick();
            bus.rd_en = 1'b0;
            pulse_abort();
            tick();
        end
`endif

        // Burst of 4 from 6 valid frames.
        base = done_seen;
        start_acq(2'd1, 4, 0, '0, 1'b1, '1);
        check("burst_busy", bus.busy, 1);
        check("burst_sample_en", bus.sample_en, 1);
        for (int k = 1; k <= 6; k++) begin
            send(mkf(k));
            if (k <= 4) exp_q.push_back(mkf(k));
            if (k == 1) check("lat_t1_empty", bus.not_empty, 0);
            if (k == 2) check("lat_t2_ne", bus.not_empty, 1);
        end
        tick();
        tick();
        check("burst_done_cnt", done_seen - base, 1);
        check("burst_busy_at_done", done_busy, 0);
        check("burst_busy_end", bus.busy, 0);
        drain("burst");

        // Rising trigger on ch2 at 0x800.
        base = done_seen;
        start_acq(2'd2, 2, 2, 12'h800, 1'b1, '1);
        check("trig_armed_busy", bus.busy, 1);
        check("trig_armed_sen", bus.sample_en, 1);
        send(mkc2(1, 12'h700));
        send(mkc2(2, 12'h7FF));
        tick();
        tick();
        check("trig_armed_empty", bus.not_empty, 0);
        send(mkc2(3, 12'h800));
        exp_q.push_back(mkc2(3, 12'h800));
        send(mkc2(4, 12'h900));
        exp_q.push_back(mkc2(4, 12'h900));
        tick();
        tick();
        check("trig_done_cnt", done_seen - base, 1);
        check("trig_busy_end", bus.busy, 0);
        drain("trig");

        // Falling trigger on ch2 at 0x400, single frame.
        base = done_seen;
        start_acq(2'd2, 1, 2, 12'h400, 1'b0, '1);
        send(mkc2(5, 12'h300));
        send(mkc2(6, 12'h500));
        send(mkc2(7, 12'h3FF));
        exp_q.push_back(mkc2(7, 12'h3FF));
        send(mkc2(8, 12'h100));
        tick();
        check("fall_done_cnt", done_seen - base, 1);
        drain("fall");

        // Channel mask with abort.
        base = done_seen;
        start_acq(2'd0, 0, 0, '0, 1'b1, 8'h01);
        for (int k = 1; k <= 3; k++) begin
            send(mkf(32 + k));
            exp_q.push_back(msk(mkf(32 + k), 8'h01));
        end
        pulse_abort();
        check("abort_sen", bus.sample_en, 0);
        check("abort_busy", bus.busy, 0);
        tick();
        check("abort_no_done", done_seen - base, 0);
        drain("mask");

        // Zero-length burst.
        base = done_seen;
        start_acq(2'd1, 0, 0, '0, 1'b1, '1);
        check("len0_done", bus.done, 1);
        check("len0_busy", bus.busy, 0);
        tick();
        check("len0_empty", bus.not_empty, 0);
        check("len0_done_cnt", done_seen - base, 1);

        // Overflow in continuous mode.
        start_acq(2'd0, 0, 0, '0, 1'b1, '1);
        for (int k = 0; k < DEPTH + 3; k++) begin
            send(mkf(k));
            if (k < DEPTH) exp_q.push_back(mkf(k));
        end
        tick();
        tick();
        check("ovf_full", bus.full, 1);
        check("ovf_cnt", bus.overflow_cnt, 3);
        check("ovf_head", bus.dout[SMP_W-1:0], exp_q.pop_front());
        f = mkf(200);
        send(f);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        exp_q.push_back(f);
        check("ovf_full_after_rw", bus.full, 1);
        check("ovf_cnt_hold", bus.overflow_cnt, 3);
        pulse_abort();
        check("ovf_kept_after_abort", bus.overflow_cnt, 3);
        drain("ovf");

        // Asynchronous reset mid-burst.
        start_acq(2'd1, 10, 0, '0, 1'b1, '1);
        for (int k = 1; k <= 5; k++) send(mkf(64 + k));
        tick();
        check("prerst_ne", bus.not_empty, 1);
        check("prerst_busy", bus.busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_ne", bus.not_empty, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_ovf", bus.overflow_cnt, 0);
        check("rst_mid_sen", bus.sample_en, 0);
        check("rst_mid_dout", bus.dout, 0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("post_rst_empty", bus.not_empty, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
